i2c_controller: RTL



---
 rtl/i2c_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_controller.sv
// Byte-level single-master I2C controller: runs one START/STOP/READ_BYTE/WRITE_BYTE per request.
// Latency 4*DIVIDER+1 (START/STOP) or 36*DIVIDER+1 (bytes) cycles; client holds enableI2C until completeI2C.
module i2c_controller #(
    parameter int DIVIDER = 67
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] instructionI2C,
    input  logic       enableI2C,
    input  logic [7:0] byteToSendI2C,
    output logic [7:0] byteReceivedI2C,
    output logic       completeI2C,
    output logic       ackReceived,
    output logic       scl,
    input  logic       sdaIn,
    output logic       sdaOe
);

    typedef enum logic [2:0] {
        IDLE,
        ST_START,
        ST_STOP,
        ST_READ,
        ST_WRITE,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic       ack_q, ack_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic       complete_q, complete_d;
    logic       sda_meta_q, sda_meta_d;
    logic       sda_sync_q, sda_sync_d;

    logic       busy;
    logic       tick;
    logic [3:0] last_bit;

    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign tick     = busy && (cnt_q == 8'(DIVIDER - 1));
    assign last_bit = ((state_q == ST_START) || (state_q == ST_STOP)) ? 4'd0 : 4'd8;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        ack_d      = ack_q;
        scl_d      = scl_q;
        sda_oe_d   = sda_oe_q;
        complete_d = complete_q;
        // SDA pad is asynchronous to clk
        sda_meta_d = sdaIn;
        sda_sync_d = sda_meta_q;

        if (busy) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (enableI2C) begin
                    complete_d = 1'b0;
                    cnt_d      = 8'd0;
                    phase_d    = 2'd0;
                    bit_d      = 4'd0;
                    tx_d       = byteToSendI2C;
                    case (instructionI2C)
                        2'd0: begin
                            state_d  = ST_START;
                            sda_oe_d = 1'b0;
                        end
                        2'd1: begin
                            state_d  = ST_STOP;
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b1;
                        end
                        2'd2: begin
                            state_d  = ST_READ;
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                        default: begin
                            state_d  = ST_WRITE;
                            scl_d    = 1'b0;
                            sda_oe_d = ~byteToSendI2C[7];
                        end
                    endcase
                end
            end
            DONE: begin
                if (!enableI2C) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        bit_d = bit_q + 4'd1;
                    end
                    if ((phase_q == 2'd3) && (bit_q == last_bit)) begin
                        // SDA is always released between instructions
                        state_d    = DONE;
                        complete_d = 1'b1;
                        sda_oe_d   = 1'b0;
                        if (state_q == ST_READ) begin
                            rx_d = shift_q;
                        end
                    end else begin
                        // Actions below are those of the phase being entered
                        case (phase_q)
                            2'd0: scl_d = 1'b1;
                            2'd1: begin
                                if (state_q == ST_START) begin
                                    sda_oe_d = 1'b1;
                                end else if (state_q == ST_STOP) begin
                                    sda_oe_d = 1'b0;
                                end else if ((state_q == ST_READ) && (bit_q != 4'd8)) begin
                                    shift_d = {shift_q[6:0], sda_sync_q};
                                end else if ((state_q == ST_WRITE) && (bit_q == 4'd8)) begin
                                    ack_d = ~sda_sync_q;
                                end
                            end
                            2'd2: begin
                                if (state_q != ST_STOP) begin
                                    scl_d = 1'b0;
                                end
                            end
                            default: begin
                                scl_d = 1'b0;
                                if (state_q == ST_WRITE) begin
                                    if (bit_q == 4'd7) begin
                                        sda_oe_d = 1'b0;
                                    end else begin
                                        tx_d     = {tx_q[6:0], 1'b0};
                                        sda_oe_d = ~tx_q[6];
                                    end
                                end else begin
                                    sda_oe_d = (bit_q == 4'd7);
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            phase_q    <= 2'd0;
            bit_q      <= 4'd0;
            tx_q       <= 8'd0;
            shift_q    <= 8'd0;
            rx_q       <= 8'd0;
            ack_q      <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            complete_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            ack_q      <= ack_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            complete_q <= complete_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign byteReceivedI2C = rx_q;
    assign completeI2C     = complete_q;
    assign ackReceived     = ack_q;
    assign scl             = scl_q;
    assign sdaOe           = sda_oe_q;

endmodule
